// File: rtl/flick_debounce.sv
// Push-button conditioner: 2-flop synchronizer, debounce FSM and flick event generation.
// Optional macro FLICK_LATCH_EN turns the flick pulse into a request held until flick_ack.
`timescale 1ns/1ps

module flick_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flick_raw,
  input  logic       flick_ack,
  output logic       flick,
  output logic       flick_level,
  output logic       flick_ovr,
  output logic [7:0] press_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_WAIT   = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_WAIT   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s1, s2;
  logic             accept_c;
  logic             flick_nxt;
  logic             ovr_nxt;
  logic             level_nxt;
  logic [7:0]       press_nxt;

  // Two-flop synchronizer for the asynchronous raw level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= flick_raw;
      s2 <= s1;
    end
  end

  // State and counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOW_STABLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, counter and accept decode; only the rise qualification yields an event
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_c  = 1'b0;
    case (state)
      LOW_STABLE: begin
        if (s2) begin
          state_nxt = RISE_WAIT;
          cnt_nxt   = '0;
        end
      end
      RISE_WAIT: begin
        if (!s2) begin
          state_nxt = LOW_STABLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = HIGH_STABLE;
          accept_c  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        if (!s2) begin
          state_nxt = FALL_WAIT;
          cnt_nxt   = '0;
        end
      end
      FALL_WAIT: begin
        if (s2) begin
          state_nxt = HIGH_STABLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt = LOW_STABLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = LOW_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output next-values; level follows the next state so it rises with the event
  always_comb begin
    level_nxt = (state_nxt == HIGH_STABLE) || (state_nxt == FALL_WAIT);
    press_nxt = press_cnt + 8'(accept_c);
`ifdef FLICK_LATCH_EN
    flick_nxt = accept_c | (flick & ~flick_ack);
    ovr_nxt   = accept_c & flick & ~flick_ack;
`else
    flick_nxt = accept_c;
    ovr_nxt   = 1'b0;
`endif
  end

`ifndef FLICK_LATCH_EN
  logic unused_ack;
  assign unused_ack = flick_ack;
`endif

  // Registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flick       <= 1'b0;
      flick_level <= 1'b0;
      flick_ovr   <= 1'b0;
      press_cnt   <= 8'd0;
    end else begin
      flick       <= flick_nxt;
      flick_level <= level_nxt;
      flick_ovr   <= ovr_nxt;
      press_cnt   <= press_nxt;
    end
  end

endmodule

// File: doc/flick_debounce.md
# flick_debounce

Input conditioner that sits directly upstream of the lamp-flasher state machine and drives its `flick` input. Synchronizes the raw push-button/switch signal into the `clk` domain, rejects glitches and contact bounce shorter than a configurable stable time, and emits one clean flick event per accepted press. Also provides the debounced level and a wrapping press counter for debug.

## Interface
- `DEBOUNCE_CYCLES`, 16, number of consecutive stable synchronized samples required to accept a level change; legal range 2..65535.
- `CNT_W`, 16, width of the internal debounce counter; must hold `DEBOUNCE_CYCLES-1`.
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `flick_raw`  input  1  raw asynchronous button/switch level, active-high.
- `flick_ack`  input  1  consumer acknowledge; used only when `FLICK_LATCH_EN` is defined.
- `flick`  output  1  conditioned flick event to the flasher.
- `flick_level`  output  1  debounced level of `flick_raw`.
- `flick_ovr`  output  1  one-cycle pulse: a new press was accepted while a latched request was still pending.
- `press_cnt`  output  8  count of accepted presses, wraps.

## Operation
- Synchronizer: two flops, `s1 <= flick_raw`, `s2 <= s1`; only `s2` is used downstream.
- Debounce FSM, 4 states:
  - `LOW_STABLE`: `s2==1` -> `RISE_WAIT`, cnt<=0.
  - `RISE_WAIT`: `s2==0` -> `LOW_STABLE` (glitch rejected, no event); else if cnt==DEBOUNCE_CYCLES-1 -> `HIGH_STABLE` and raise accept; else cnt<=cnt+1.
  - `HIGH_STABLE`: `s2==0` -> `FALL_WAIT`, cnt<=0.
  - `FALL_WAIT`: `s2==1` -> `HIGH_STABLE` (bounce on release, no new event); else if cnt==DEBOUNCE_CYCLES-1 -> `LOW_STABLE`; else cnt<=cnt+1.
- Only the `RISE_WAIT`->`HIGH_STABLE` transition is an accepted press; releases never generate events.
- `flick_level` = 1 in `HIGH_STABLE` and `FALL_WAIT`, else 0 (registered from state).
- `press_cnt` increments by 1 on every accepted press; 255 -> 0 wrap, no saturation.
- Counter is unsigned, compared for equality only; never exceeds DEBOUNCE_CYCLES-1.
- Illegal state encodings recover to `LOW_STABLE` on the next edge.

## Timing
- Reset (async assert, sync to clk on release): state `LOW_STABLE`, cnt 0, `s1`/`s2` 0, `flick` 0, `flick_level` 0, `flick_ovr` 0, `press_cnt` 0.
- Latency: `flick_raw` stably high from before edge E0 -> `s2` high after E1 -> `RISE_WAIT` after E2 -> `HIGH_STABLE` after edge E(DEBOUNCE_CYCLES+2); `flick` (pulse mode) high for exactly the cycle following that edge.
- `flick_level` rises in the same cycle as the event; falls DEBOUNCE_CYCLES+2 edges after a stable release.
- Any `s2` low sample during `RISE_WAIT` restarts the full qualification from `LOW_STABLE`.
- Reset asserted mid-qualification or with a pending request: all state and outputs clear immediately; no event is emitted after reset release until a fresh full qualification.

## Configuration
- `FLICK_LATCH_EN` defined: `flick` is a held request. Set on accepted press, cleared on an edge where `flick_ack==1` and no press is accepted. Press accepted in the same cycle as ack: `flick` stays 1. Press accepted while `flick==1` and no ack: `flick` stays 1, `flick_ovr` pulses one cycle, `press_cnt` still increments.
- `FLICK_LATCH_EN` undefined: `flick` is a single-cycle pulse per accepted press; `flick_ack` ignored; `flick_ovr` constant 0.

## Test plan
- Reset: `rst`=0 with `flick_raw`=1 toggling -> all outputs 0 throughout; after release, press accepted only after full DEBOUNCE_CYCLES+2 edges.
- Clean press, DEBOUNCE_CYCLES=4, pulse mode: `flick_raw` 0->1 held 20 cycles -> `flick` high exactly one cycle, 6 edges after first sampling edge; `flick_level`=1; `press_cnt`=1.
- Bounce: DEBOUNCE_CYCLES=4, `flick_raw` high 3 cycles, low 1, high 3, low 1, then high 10 -> exactly one `flick` event, `press_cnt`=1; release with 2-cycle bounce -> no event, `flick_level` falls once.
- Glitch rejection: single-cycle and 3-cycle high pulses (DEBOUNCE_CYCLES=4) -> `flick`=0, `press_cnt`=0, `flick_level`=0.
- Latch mode (`FLICK_LATCH_EN`): press -> `flick` held until `flick_ack`=1 for one cycle, clears next edge; second press before ack -> `flick_ovr` one-cycle pulse, `press_cnt`=2; press coinciding with ack -> `flick` remains 1.
- Wrap: 256 accepted presses -> `press_cnt` returns to 0, 257th -> 1.
